uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing bytes from N_REQ requesters to one UART serializer,
// with completion timeout and an inter-frame gap counted in 16x-baud ticks.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_TICKS      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ready_o,
    input  logic               tick_16x_i,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_done_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic [2:0]         grant_id_o,
    output logic               busy_o,
    output logic               err_o
);
    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT_DONE, GAP} state_t;
    state_t      state;
    state_t      after_wait;
    logic [2:0]  last_id;
    logic [2:0]  win;
    logic [2:0]  idx;
    logic [7:0]  valid_pad;
    logic [63:0] data_pad;
    logic [19:0] wait_cnt;
    logic [7:0]  gap_cnt;

    // Padding to the 8-requester maximum keeps every 3-bit index in range.
    assign valid_pad  = 8'(req_valid_i);
    assign data_pad   = 64'(req_data_i);
    assign after_wait = (GAP_TICKS == 0) ? IDLE : GAP;
    assign busy_o     = state != IDLE;

    always_comb begin
        win = last_id;
        idx = last_id;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = 3'((int'(last_id) + k) % N_REQ);
            win = valid_pad[idx] ? idx : win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_id     <= 3'(N_REQ - 1);
            req_ready_o <= '0;
            tx_start_o  <= 1'b0;
            tx_data_o   <= '0;
            grant_o     <= '0;
            grant_id_o  <= '0;
            err_o       <= 1'b0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ready_o <= '0;
            tx_start_o  <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: if (|req_valid_i) begin
                    state       <= GRANT;
                    grant_o     <= N_REQ'(1) << win;
                    req_ready_o <= N_REQ'(1) << win;
                    grant_id_o  <= win;
                end
                GRANT: if (valid_pad[grant_id_o]) begin
                    state      <= START;
                    tx_data_o  <= data_pad[{grant_id_o, 3'b000} +: 8];
                    last_id    <= grant_id_o;
                    tx_start_o <= 1'b1;
                end else begin
                    state      <= IDLE;
                    grant_o    <= '0;
                    grant_id_o <= '0;
                end
                START: begin
                    state    <= WAIT_DONE;
                    wait_cnt <= '0;
                end
                WAIT_DONE: if (tx_done_i || wait_cnt == 20'(TIMEOUT_CYCLES - 1)) begin
                    state   <= after_wait;
                    err_o   <= !tx_done_i;
                    gap_cnt <= '0;
                    if (GAP_TICKS == 0) begin
                        grant_o    <= '0;
                        grant_id_o <= '0;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 20'd1;
                end
                GAP: if (gap_cnt == 8'(GAP_TICKS)) begin
                    state      <= IDLE;
                    grant_o    <= '0;
                    grant_id_o <= '0;
                end else if (tick_16x_i) begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
